// File: rtl/datapath_run_ctrl.sv
// Run controller for the single-cycle datapath: core-reset sequencer, run/halt FSM
// and circular writeback trace buffer. Define TRACE_TS_EN to add cycle stamps per entry.
module datapath_run_ctrl #(
    parameter int                DATA_W     = 32,
    parameter int                RST_CYCLES = 100,
    parameter int                DEPTH      = 16,
    parameter int                MAX_CYCLES = 1024,
    parameter logic [DATA_W-1:0] HALT_VALUE = 32'hFFFF_FFFF
) (
    input  logic                     Clk,
    input  logic                     Rst,
    output logic                     CoreRst,
    input  logic [DATA_W-1:0]        WriteData,
    input  logic                     WbValid,
    output logic                     Halted,
    output logic [31:0]              CycleCount,
    input  logic [$clog2(DEPTH)-1:0] TraceRdAddr,
    output logic [DATA_W-1:0]        TraceRdData,
`ifdef TRACE_TS_EN
    output logic [31:0]              TraceRdStamp,
`endif
    output logic [$clog2(DEPTH):0]   TraceCount,
    output logic                     Overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        RESET_HOLD,
        RUN,
        HALTED
    } state_t;

    state_t          state;
    logic [31:0]     hold_cnt;
    logic [AW-1:0]   wr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
`ifdef TRACE_TS_EN
    logic [31:0]     stamp_mem [DEPTH];
`endif

    logic          wr_en;
    logic          halt_req;
    logic          rd_hit;
    logic [AW-1:0] rd_idx;

    assign wr_en    = (state == RUN) && WbValid;
    assign halt_req = (state == RUN) &&
                      ((WbValid && (WriteData == HALT_VALUE)) ||
                       (CycleCount == 32'(MAX_CYCLES - 1)));
    assign rd_hit   = {1'b0, TraceRdAddr} < TraceCount;
    // Oldest entry sits TraceCount slots behind the write pointer.
    assign rd_idx   = wr_ptr - TraceCount[AW-1:0] + TraceRdAddr;

    // NOTE: trace storage has no reset so it maps onto plain RAM; the valid
    // window is defined solely by wr_ptr and TraceCount, which are reset.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= WriteData;
`ifdef TRACE_TS_EN
            stamp_mem[wr_ptr] <= CycleCount;
`endif
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= RESET_HOLD;
            CoreRst     <= 1'b1;
            Halted      <= 1'b0;
            CycleCount  <= '0;
            TraceCount  <= '0;
            Overflow    <= 1'b0;
            TraceRdData <= '0;
`ifdef TRACE_TS_EN
            TraceRdStamp <= '0;
`endif
            wr_ptr      <= '0;
            hold_cnt    <= '0;
        end else begin
            TraceRdData <= rd_hit ? mem[rd_idx] : '0;
`ifdef TRACE_TS_EN
            TraceRdStamp <= rd_hit ? stamp_mem[rd_idx] : '0;
`endif
            unique case (state)
                RESET_HOLD: begin
                    hold_cnt <= hold_cnt + 32'd1;
                    if (hold_cnt == 32'(RST_CYCLES - 1)) begin
                        state   <= RUN;
                        CoreRst <= 1'b0;
                    end
                end
                RUN: begin
                    CycleCount <= CycleCount + 32'd1;
                    if (wr_en) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        if (TraceCount == (AW + 1)'(DEPTH))
                            Overflow <= 1'b1;
                        else
                            TraceCount <= TraceCount + (AW + 1)'(1);
                    end
                    if (halt_req) begin
                        state   <= HALTED;
                        Halted  <= 1'b1;
                        CoreRst <= 1'b1;
                    end
                end
                HALTED: begin
                    // Everything frozen until Rst.
                end
                default: begin
                    state   <= RESET_HOLD;
                    CoreRst <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/datapath_run_ctrl.md
Name: datapath_run_ctrl

Overview:
Parametrised run controller for the single-cycle datapath. It replaces the fixed reset hold and free-running clock of the current top-level bench with three functions: a programmable core-reset sequencer, a run/halt state machine, and a circular writeback trace buffer. The trace buffer captures WriteData from the datapath and exposes it through a read-back port. It sits between the system reset and the datapath core, and is used in simulation and on FPGA.

Parameters:
DATA_W, 32, width of WriteData and trace entries
RST_CYCLES, 100, clock edges CoreRst is held after Rst deasserts (>=1)
DEPTH, 16, trace buffer entries (power of 2, >=2)
MAX_CYCLES, 1024, run-cycle limit before forced halt (>=1)
HALT_VALUE, 32'hFFFF_FFFF, writeback value that requests halt

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous, active-high reset
CoreRst  out  1  reset to datapath core, active-high, registered
WriteData  in  DATA_W  datapath writeback value
WbValid  in  1  WriteData qualifier, sampled on Clk rising edge
Halted  out  1  high in HALTED state
CycleCount  out  32  run cycles elapsed
TraceRdAddr  in  $clog2(DEPTH)  read index, 0 = oldest entry
TraceRdData  out  DATA_W  registered read data
TraceCount  out  $clog2(DEPTH)+1  valid entries, saturates at DEPTH
Overflow  out  1  sticky; set when an entry is overwritten

Behaviour:
- Reset: one clock (Clk); Rst is asynchronous and active-high. Asserting Rst forces, immediately and regardless of Clk:
  - state RESET_HOLD, CoreRst=1
  - Halted=0, CycleCount=0, TraceCount=0, Overflow=0, TraceRdData=0
  - write pointer=0, hold counter=0
  - Trace RAM contents are not cleared. This also applies to reset mid-run.
- FSM states: RESET_HOLD, RUN, HALTED.
- RESET_HOLD:
  - Hold counter increments on each rising edge while Rst=0.
  - On the RST_CYCLES-th edge, go to RUN; CoreRst=0 from that edge.
- RUN, every edge:
  - CycleCount += 1.
  - If WbValid=1, write WriteData to mem[wr_ptr]; wr_ptr wraps modulo DEPTH.
  - TraceCount increments, saturating at DEPTH.
  - If a write occurs while TraceCount==DEPTH, set Overflow (oldest entry lost).
- Halt conditions (evaluated in RUN):
  - (a) WbValid=1 and WriteData==HALT_VALUE. The halting value is still captured.
  - (b) CycleCount==MAX_CYCLES-1 at the edge. CycleCount ends at exactly MAX_CYCLES.
  - If both are true on the same edge, halt once; the value is captured and CycleCount increments.
  - Next state HALTED; CoreRst=1 from that edge.
- HALTED:
  - CycleCount, trace contents, TraceCount and Overflow are frozen; WbValid is ignored.
  - Only Rst leaves this state.
- Trace read:
  - TraceRdData <= mem[(wr_ptr - TraceCount + TraceRdAddr) mod DEPTH], one cycle latency, valid in every state.
  - TraceRdAddr >= TraceCount returns 0.
  - Read and write on the same edge: the read uses pre-edge wr_ptr, TraceCount and mem contents.
- Arithmetic:
  - CycleCount is 32-bit unsigned; cannot wrap before MAX_CYCLES.
  - Pointer math is modulo DEPTH.

Optional Feature:
- Macro: TRACE_TS_EN.
- Defined:
  - Each trace entry also stores the CycleCount value present at the write edge, pre-increment.
  - Extra output port TraceRdStamp out 32 returns the stamp with the same latency, addressing and zero rule as TraceRdData.
- Undefined: no stamp storage and no TraceRdStamp port; behaviour otherwise identical.

Test Plan:
Bench overrides: RST_CYCLES=4, DEPTH=4, MAX_CYCLES=20.
- Reset sequencing: Rst=1 for 3 edges, then 0 -> CoreRst stays 1 for exactly 4 edges then 0; Halted=0; CycleCount=0 when CoreRst falls.
- Capture in order: WbValid=1 with values 0x11, 0x22, 0x33 on consecutive edges -> TraceCount=3; reads at addr 0/1/2 give 0x11/0x22/0x33 one cycle after the address; addr 3 gives 0.
- Wrap and overflow: write 0xA0..0xA5 (6 writes) -> TraceCount=4, Overflow=1, addr0=0xA2, addr3=0xA5.
- Halt on sentinel: write 0x5, then 0xFFFFFFFF at run cycle 7 -> Halted=1 and CoreRst=1 after that edge; last entry 0xFFFFFFFF; CycleCount=8; later WbValid writes ignored.
- Halt on limit: no sentinel -> Halted after 20 run edges; CycleCount=20 and stays 20.
- Async reset mid-run: assert Rst between edges at CycleCount=9 -> CoreRst=1, CycleCount=0, TraceCount=0, Overflow=0 without waiting for a Clk edge; the reset sequence then repeats.
